// File: rtl/shift_alu_pkg.sv
// Shared constants for the sequential shift-then-ALU datapath:
// ALU opcodes, shift modes, FSM state encoding and NZCV flag positions.
package shift_alu_pkg;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Shift mode select
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_alu_seq_alu.sv
// Combinational ALU with NZCV flag generation. SUB is computed as
// a + ~b + 1 so that the carry-out directly means "no borrow".
module alu_core
    import shift_alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] dif_ext;

    // Both adder paths are always computed; carry is the extra top bit.
    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign dif_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Operation select and flag formation.
    always_comb begin
        y     = b;
        flags = 4'b0000;
        case (alu_control)
            ALU_ADD: begin
                y             = sum_ext[WIDTH-1:0];
                flags[FLAG_C] = sum_ext[WIDTH];
                // Same-sign operands producing an opposite-sign result overflowed.
                flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                y             = dif_ext[WIDTH-1:0];
                flags[FLAG_C] = dif_ext[WIDTH];
                // Differing-sign operands whose result sign departs from a overflowed.
                flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: y = a & b;
            ALU_ORR: y = a | b;
            ALU_XOR: y = a ^ b;
            default: y = b;
        endcase
        flags[FLAG_N] = y[WIDTH-1];
        flags[FLAG_Z] = (y == '0);
    end

endmodule

// File: rtl/shift_alu_seq.sv
// Sequential shift-then-ALU unit. Operand a is shifted one bit per cycle
// (so out-of-range shift amounts saturate naturally for LSL/LSR/ASR and
// wrap for ROR), then combined with b. Latency from accepted start to the
// done pulse is shamt+2 edges.
module shift_alu_seq
    import shift_alu_pkg::*;
#(
    parameter  int WIDTH = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    input  logic [1:0]       shift_mode,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [1:0]       mode_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] alu_y;
    logic [3:0]       alu_f;

    // One-position shift step; ROR moves bit 0 into the MSB.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       mode);
        case (mode)
            SH_LSL:  shift1 = {v[WIDTH-2:0], 1'b0};
            SH_LSR:  shift1 = {1'b0, v[WIDTH-1:1]};
            SH_ASR:  shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift1 = {v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a           (sh_q),
        .b           (b_q),
        .alu_control (op_q),
        .y           (alu_y),
        .flags       (alu_f)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == '0) state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Operand latch, iterative shifter and result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            mode_q    <= '0;
            cnt_q     <= '0;
            result    <= '0;
            alu_flags <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sh_q   <= a;
                        b_q    <= b;
                        op_q   <= alu_control;
                        mode_q <= shift_mode;
                        cnt_q  <= shamt;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        sh_q  <= shift1(sh_q, mode_q);
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EXEC: begin
                    result    <= alu_y;
                    alu_flags <= alu_f;
                end
                default: ;
            endcase
        end
    end

endmodule
